symbol_feeder: RTL and testbench



---
 rtl/symbol_feeder.sv | 175 +++++++++++++++++
 tb/tb_symbol_feeder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/symbol_feeder.sv
// symbol_feeder
// Upstream stage of the 2-bit symbol sequence detector. Packs a serial bit
// stream into 2-bit symbols (MSB first), buffers them in a small FIFO and
// issues at most one symbol per cycle on num. Symbol 0 is the detector's
// idle code, so it is never buffered and num = 0 whenever nothing is sent.
//
// Parameters:
//   DEPTH       FIFO entries (power of 2, >= 2)
//   AW          FIFO address width, log2(DEPTH)
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   bit_in      serial data bit
//   bit_vld     bit_in is valid this cycle
//   frame_start realign pairing; a valid bit in the same cycle is an MSB
//   hold        downstream stall; no symbol issued while high
//   num         registered symbol to the detector (0 = idle)
//   sym_vld     registered; num carries a FIFO symbol
//   full        FIFO holds DEPTH entries
//   level       FIFO occupancy, 0..DEPTH
//   drop        one-cycle registered pulse when a symbol is lost to a full FIFO
//   drop_cnt    saturating drop counter (only with SYMBOL_FEEDER_STATS_EN)
//
// Optional feature macro: SYMBOL_FEEDER_STATS_EN adds the drop_cnt port.
module symbol_feeder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bit_in,
    input  logic          bit_vld,
    input  logic          frame_start,
    input  logic          hold,
    output logic [1:0]    num,
    output logic          sym_vld,
    output logic          full,
    output logic [AW:0]   level,
    output logic          drop
`ifdef SYMBOL_FEEDER_STATS_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

    typedef enum logic {
        P0 = 1'b0,  // expecting MSB
        P1 = 1'b1   // expecting LSB
    } phase_t;

    phase_t         r_phase;
    phase_t         w_phase_next;
    logic           r_msb;
    logic           w_msb_next;
    logic           w_push_req;
    logic [1:0]     w_sym;

    logic [1:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_level;
    logic [1:0]     r_num;
    logic           r_sym_vld;
    logic           r_drop;

    logic           w_full;
    logic           w_pop;
    logic           w_wr;
    logic           w_drop;

    // ---------------- pairing FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= P0;
            r_msb   <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_msb   <= w_msb_next;
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        w_msb_next   = r_msb;
        w_push_req   = 1'b0;
        w_sym        = {r_msb, bit_in};
        if (frame_start) begin
            // Realign: any half-assembled symbol is abandoned without a drop.
            if (bit_vld) begin
                w_msb_next   = bit_in;
                w_phase_next = P1;
            end else begin
                w_phase_next = P0;
            end
        end else if (bit_vld) begin
            case (r_phase)
                P0: begin
                    w_msb_next   = bit_in;
                    w_phase_next = P1;
                end
                P1: begin
                    // The idle code carries no information; discard it.
                    w_push_req   = (w_sym != 2'b00);
                    w_phase_next = P0;
                end
                default: w_phase_next = P0;
            endcase
        end
    end

    // ---------------- FIFO control ----------------
    assign w_full = (r_level == L_DEPTH);
    assign w_pop  = !hold && (r_level != '0);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_wr   = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_num     <= 2'b00;
            r_sym_vld <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_num     <= r_mem[r_rd_ptr];
                r_sym_vld <= 1'b1;
            end else begin
                r_num     <= 2'b00;
                r_sym_vld <= 1'b0;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SYMBOL_FEEDER_STATS_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign num     = r_num;
    assign sym_vld = r_sym_vld;
    assign level   = r_level;
    assign full    = w_full;
    assign drop    = r_drop;

endmodule

// File: tb/tb_symbol_feeder.sv
module tb_symbol_feeder;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       frame_start;
    logic       hold;
    logic [1:0] num;
    logic       sym_vld;
    logic       full;
    logic [2:0] level;
    logic       drop;
`ifdef SYMBOL_FEEDER_STATS_EN
    logic [7:0] drop_cnt;
`endif

    int test_cnt = 0;
    int fail_cnt = 0;
    logic [1:0] exp_q [$];

    symbol_feeder #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .frame_start (frame_start),
        .hold        (hold),
        .num         (num),
        .sym_vld     (sym_vld),
        .full        (full),
        .level       (level),
        .drop        (drop)
`ifdef SYMBOL_FEEDER_STATS_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        test_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic fs);
        bit_in      = b;
        bit_vld     = 1'b1;
        frame_start = fs;
        tick();
        bit_vld     = 1'b0;
        frame_start = 1'b0;
        bit_in      = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] s);
        send(s[1], 1'b0);
        send(s[0], 1'b0);
    endtask

    // Monitor: every issued symbol must match the head of the expected queue,
    // and num must be 0 whenever sym_vld is low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sym_vld) begin
                if (exp_q.size() == 0) begin
                    test_cnt++;
                    fail_cnt++;
                    $display("FAIL unexpected_symbol: got %0d expected none", num);
                end else begin
                    check("num", int'(num), int'(exp_q.pop_front()));
                end
            end else if (num != 2'b00) begin
                check("idle_num", int'(num), 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; frame_start = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_num", int'(num), 0);
        check("rst_sym_vld", int'(sym_vld), 0);
        check("rst_level", int'(level), 0);
        check("rst_full", int'(full), 0);
        check("rst_drop", int'(drop), 0);
        rst_n = 1'b1;
        tick();

        // Basic packing: 0,1,1,0,1,1 -> 01, 10, 11
        exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        send(0, 0); send(1, 0); send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        check("lat_level_after_lsb", int'(level), 1);
        check("lat_no_bypass", int'(sym_vld), 0);
        tick();
        check("lat_issued", int'(sym_vld), 1);
        check("lat_level_after_pop", int'(level), 0);
        repeat (3) tick();

        // Idle code: 00 discarded, 01 issued
        exp_q.push_back(2'b01);
        send(0, 0); send(0, 0);
        check("idle_level", int'(level), 0);
        check("idle_drop", int'(drop), 0);
        send(0, 0); send(1, 0);
        check("idle_then_01_level", int'(level), 1);
        repeat (3) tick();

        // Full / drop
        hold = 1'b1;
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        send_sym(2'b01); send_sym(2'b10); send_sym(2'b11); send_sym(2'b01);
        check("full_level", int'(level), 4);
        check("full_flag", int'(full), 1);
        send_sym(2'b10);
        check("drop_pulse", int'(drop), 1);
        check("drop_level", int'(level), 4);
        tick();
        check("drop_one_cycle", int'(drop), 0);
        hold = 1'b0;
        repeat (4) tick();
        check("drain_level", int'(level), 0);
        tick();
        check("drain_idle", int'(sym_vld), 0);
        repeat (2) tick();

        // Push and pop together at full
        hold = 1'b1;
        exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b11);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        send_sym(2'b01); send_sym(2'b10); send_sym(2'b11); send_sym(2'b01);
        check("pp_full_level", int'(level), 4);
        send(1, 0);
        hold = 1'b0;
        send(0, 0);
        check("pp_level", int'(level), 4);
        check("pp_no_drop", int'(drop), 0);
        check("pp_popped", int'(sym_vld), 1);
        repeat (6) tick();
        check("pp_drain_level", int'(level), 0);

        // frame_start realign: 1, (fs)0, 1 -> 01
        exp_q.push_back(2'b01);
        send(1, 0); send(0, 1); send(1, 0);
        check("fs_level", int'(level), 1);
        check("fs_no_drop", int'(drop), 0);
        repeat (3) tick();

        // Mid-operation asynchronous reset
        hold = 1'b1;
        send_sym(2'b11); send_sym(2'b10); send(1, 0);
        check("pre_rst_level", int'(level), 2);
        #3 rst_n = 1'b0;
        #1;
        check("arst_num", int'(num), 0);
        check("arst_sym_vld", int'(sym_vld), 0);
        check("arst_level", int'(level), 0);
        check("arst_full", int'(full), 0);
        check("arst_drop", int'(drop), 0);
        #2 rst_n = 1'b1;
        hold = 1'b0;
        // Half symbol (MSB 1) was discarded by reset, so 0,1 pairs to 01
        exp_q.push_back(2'b01);
        send(0, 0); send(1, 0);
        check("post_rst_level", int'(level), 1);
        repeat (3) tick();

`ifdef SYMBOL_FEEDER_STATS_EN
        check("cnt_start", int'(drop_cnt), 0);
        hold = 1'b1;
        repeat (4) send_sym(2'b01);
        repeat (300) send_sym(2'b01);
        check("cnt_saturate", int'(drop_cnt), 255);
        rst_n = 1'b0;
        #1;
        check("cnt_reset", int'(drop_cnt), 0);
        #2 rst_n = 1'b1;
        hold = 1'b0;
        repeat (2) tick();
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
